// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// The serial line is double-flopped into the core clock domain, each bit is
// sampled at its mid-point with an integer clocks-per-bit counter, and good
// bytes are pushed into the FIFO on the stop-bit sample cycle.
//
// Ports
//   clk           core clock, all logic on its rising edge
//   rst           asynchronous active-low reset
//   rx_i          serial line, idle high, asynchronous to clk
//   rd_en_i       pop the FIFO head (ignored while the FIFO is empty)
//   data_o        FIFO head byte, valid whenever fifo_empty_o = 0
//   fifo_empty_o  FIFO holds no bytes
//   fifo_full_o   FIFO holds 2**FIFO_ADDR_BITS bytes
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   overflow_o    one-cycle pulse: received byte dropped, FIFO full
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ       = 52_000_000,
  parameter int BAUD           = 115_200,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       rd_en_i,
  output logic [7:0] data_o,
  output logic       fifo_empty_o,
  output logic       fifo_full_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH        = 2 ** FIFO_ADDR_BITS;
  localparam int PTR_W        = FIFO_ADDR_BITS + 1;

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO      = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_s;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q,      sh_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q,  overflow_d;
  logic             push_req_s;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_ok_s;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; flops reset to the idle line level so a reset
  // never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_s = rx_sync_q;

  // ---------------------------------------------------------------------------
  // Receiver state, counters, shift register and pulse outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= CNT_ZERO;
      bit_idx_q   <= 3'd0;
      sh_q        <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver next-state logic. The start bit is re-checked at its mid-point
  // so short low glitches fall back to IDLE; after that every sample lands a
  // whole bit period later, i.e. in the middle of each following bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    push_req_s  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = CNT_ZERO;
        end else begin
          clk_cnt_d = CNT_ZERO;
        end
      end

      S_START: begin
        if (clk_cnt_q == CNT_HALF_LAST) begin
          clk_cnt_d = CNT_ZERO;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == CNT_BIT_LAST) begin
          clk_cnt_d       = CNT_ZERO;
          sh_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == CNT_BIT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          if (rx_s) begin
            push_req_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            // Bad stop bit: drop the byte and park until the line returns
            // high, so a held-low line (break) reports exactly once.
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = CNT_ZERO;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO control. Pointers carry one extra wrap bit so full and empty are
  // distinguishable. A pop in the same cycle as a push to a full FIFO frees
  // the slot, so the push is accepted and no overflow is reported.
  // ---------------------------------------------------------------------------
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[FIFO_ADDR_BITS] != rd_ptr_q[FIFO_ADDR_BITS]) &&
                     (wr_ptr_q[FIFO_ADDR_BITS-1:0] == rd_ptr_q[FIFO_ADDR_BITS-1:0]);
  assign pop_s     = rd_en_i & ~empty_s;
  assign push_ok_s = push_req_s & (~full_s | pop_s);

  // Pointer next-state and overflow pulse.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = 1'b0;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      overflow_d = push_req_s;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so data_o reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q[FIFO_ADDR_BITS-1:0]] <= sh_q;
    end else begin
      mem_q <= mem_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_o       = mem_q[rd_ptr_q[FIFO_ADDR_BITS-1:0]];
  assign fifo_empty_o = empty_s;
  assign fifo_full_o  = full_s;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;

endmodule
